// File: rtl/packet_encoder.sv
// Builds one router packet per encode request: a header word followed by
// NUMBER_PACKET-1 payload words read from memory, all streamed into input FIFO 0.
module packet_encoder #(
  parameter int AURORA_DATA_WIDTH      = 64,
  parameter int ADDR_WIDTH             = 10,
  parameter int NUMBER_PACKET          = 19,
  parameter int RECOGNIZE_ROUTER_WIDTH = 2,
  parameter logic [RECOGNIZE_ROUTER_WIDTH-1:0] ROUTER_ID = 2'b00,
  parameter logic [1:0] INIT_TTL       = 2'b11
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         ctrl_encode_valid_i,
  output logic                         ctrl_encode_ready_o,
  input  logic [ADDR_WIDTH-1:0]        enc_src_addr,
  input  logic [ADDR_WIDTH-1:0]        enc_dst_addr,
  output logic                         encode_done,
  output logic                         mem_rd_en,
  output logic [ADDR_WIDTH-1:0]        mem_rd_addr,
  input  logic [AURORA_DATA_WIDTH-1:0] mem_rd_data,
  input  logic                         fifo_full,
  output logic                         fifo_wr_en,
  output logic [AURORA_DATA_WIDTH-1:0] fifo_wr_data
);

  localparam int CW = 5;
  localparam logic [CW-1:0] LAST_CNT = CW'(NUMBER_PACKET - 2);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_HDR  = 3'd1,
    S_RD   = 3'd2,
    S_WAIT = 3'd3,
    S_WR   = 3'd4,
    S_DONE = 3'd5
  } state_t;

  state_t                         state, state_next;
  logic [CW-1:0]                  cnt;
  logic [ADDR_WIDTH-1:0]          src_q, dst_q;
  logic [AURORA_DATA_WIDTH-1:0]   data_reg;
  logic [AURORA_DATA_WIDTH-1:0]   header;

  always_comb begin
    header = '0;
    header[RECOGNIZE_ROUTER_WIDTH-1:0] = ROUTER_ID;
    header[6:2]   = 5'(NUMBER_PACKET - 1);
    header[8:7]   = INIT_TTL;
    header[18:9]  = 10'(dst_q);
    header[28:19] = 10'(src_q);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      cnt      <= '0;
      src_q    <= '0;
      dst_q    <= '0;
      data_reg <= '0;
    end else begin
      state <= state_next;
      if (state == S_IDLE && ctrl_encode_valid_i) begin
        src_q <= enc_src_addr;
        dst_q <= enc_dst_addr;
        cnt   <= '0;
      end
      if (state == S_WAIT) data_reg <= mem_rd_data;
      // Count advances only on an accepted payload write that is not the last one.
      if (state == S_WR && !fifo_full && cnt != LAST_CNT) cnt <= cnt + 1'b1;
    end
  end

  always_comb begin
    state_next          = state;
    ctrl_encode_ready_o = 1'b0;
    encode_done         = 1'b0;
    mem_rd_en           = 1'b0;
    mem_rd_addr         = '0;
    fifo_wr_en          = 1'b0;
    fifo_wr_data        = '0;
    case (state)
      S_IDLE: begin
        ctrl_encode_ready_o = 1'b1;
        if (ctrl_encode_valid_i) state_next = S_HDR;
      end
      S_HDR: begin
        fifo_wr_data = header;
        fifo_wr_en   = !fifo_full;
        if (!fifo_full) state_next = S_RD;
      end
      S_RD: begin
        mem_rd_en   = 1'b1;
        mem_rd_addr = src_q + ADDR_WIDTH'(cnt);
        state_next  = S_WAIT;
      end
      S_WAIT: state_next = S_WR;
      S_WR: begin
        fifo_wr_data = data_reg;
        fifo_wr_en   = !fifo_full;
        if (!fifo_full) state_next = (cnt == LAST_CNT) ? S_DONE : S_RD;
      end
      S_DONE: begin
        encode_done = 1'b1;
        state_next  = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_packet_encoder.sv
// Directed bench for packet_encoder: packet content, timing, backpressure,
// address wrap, busy requests, mid-packet reset and back-to-back requests.
module tb_packet_encoder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid;
  logic        ready;
  logic [9:0]  src, dst;
  logic        done;
  logic        rd_en;
  logic [9:0]  rd_addr;
  logic [63:0] rd_data = '0;
  logic        full;
  logic        wr_en;
  logic [63:0] wr_data;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int c0      = 0;

  logic [63:0] wr_q[$];
  int          wr_c_q[$];
  logic [9:0]  rd_q[$];
  int          done_c_q[$];
  logic [63:0] exp_q[$];
  bit          rdy_log[4096];

  localparam int M_PLAIN = 0, M_BP = 1, M_BUSY = 2, M_RST = 3, M_B2B = 4;

  packet_encoder dut (
    .clk(clk), .rst_n(rst_n),
    .ctrl_encode_valid_i(valid), .ctrl_encode_ready_o(ready),
    .enc_src_addr(src), .enc_dst_addr(dst),
    .encode_done(done),
    .mem_rd_en(rd_en), .mem_rd_addr(rd_addr), .mem_rd_data(rd_data),
    .fifo_full(full), .fifo_wr_en(wr_en), .fifo_wr_data(wr_data)
  );

  // clock / reset block
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // memory model: word at address a is {54'h0, a}, one cycle read latency
  always @(posedge clk) if (rd_en) rd_data <= {54'h0, rd_addr};

  // monitor sampling on the falling edge
  always @(negedge clk) begin
    if (cyc < 4096) rdy_log[cyc] = ready;
    if (wr_en) begin wr_q.push_back(wr_data); wr_c_q.push_back(cyc); end
    if (rd_en) rd_q.push_back(rd_addr);
    if (done) done_c_q.push_back(cyc);
    if (full) begin
      n_tests++;
      if (wr_en !== 1'b0) begin
        n_fail++;
        $display("FAIL wr_while_full: cycle %0d wr_en=%b, required 0", cyc, wr_en);
      end
    end
  end

  function automatic logic [63:0] exp_hdr(input logic [9:0] s, input logic [9:0] d);
    return {35'h0, s, d, 2'b11, 5'd18, 2'b00};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs;
    wr_q.delete(); wr_c_q.delete(); rd_q.delete(); done_c_q.delete(); exp_q.delete();
  endtask

  // Drives n cycles starting at a cycle boundary; cycle 0 carries the request.
  task automatic run_cycles(input int n, input int mode, input logic [9:0] s, input logic [9:0] d,
                            input logic [9:0] s2, input logic [9:0] d2);
    c0 = cyc;
    for (int r = 0; r < n; r++) begin
      valid = (r == 0) || (mode == M_BUSY && (r == 10 || r == 56)) || (mode == M_B2B && r == 57);
      src   = (mode == M_B2B && r >= 57) ? s2 : ((mode == M_BUSY && r != 0) ? 10'h155 : s);
      dst   = (mode == M_B2B && r >= 57) ? d2 : ((mode == M_BUSY && r != 0) ? 10'h155 : d);
      full  = (mode == M_BP) && ((r >= 1 && r <= 5) || (r >= 30 && r <= 32));
      rst_n = !(mode == M_RST && r == 20);
      tick();
    end
    valid = 1'b0; full = 1'b0; rst_n = 1'b1; src = '0; dst = '0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; valid = 1'b0; full = 1'b0; src = '0; dst = '0;
    tick(); tick();
    @(negedge clk);
    n_tests++; if (ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", ready); end
    n_tests++; if (wr_en !== 1'b0) begin n_fail++; $display("FAIL reset_wr_en: got %b want 0", wr_en); end
    n_tests++; if (rd_en !== 1'b0) begin n_fail++; $display("FAIL reset_rd_en: got %b want 0", rd_en); end
    n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
    n_tests++; if (wr_data !== 64'h0) begin n_fail++; $display("FAIL reset_wr_data: got %h want 0", wr_data); end
    n_tests++; if (rd_addr !== 10'h0) begin n_fail++; $display("FAIL reset_rd_addr: got %h want 0", rd_addr); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic;
    clear_logs();
    run_cycles(70, M_PLAIN, 10'h010, 10'h2A5, 10'h0, 10'h0);
    exp_q.push_back(64'h0000_0000_0085_4BC8);
    for (int i = 0; i < 18; i++) exp_q.push_back(64'(10'h010 + i));
    n_tests++;
    if (wr_q.size() !== 19) begin n_fail++; $display("FAIL basic_count: got %0d want 19", wr_q.size()); end
    else begin
      for (int i = 0; i < 19; i++) begin
        n_tests++;
        if (wr_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL basic_word%0d: got %h want %h", i, wr_q[i], exp_q[i]); end
      end
      n_tests++; if (wr_c_q[0] - c0 !== 1) begin n_fail++; $display("FAIL basic_hdr_cycle: got %0d want 1", wr_c_q[0] - c0); end
      n_tests++; if (wr_c_q[1] - c0 !== 4) begin n_fail++; $display("FAIL basic_w0_cycle: got %0d want 4", wr_c_q[1] - c0); end
      n_tests++; if (wr_c_q[18] - c0 !== 55) begin n_fail++; $display("FAIL basic_last_cycle: got %0d want 55", wr_c_q[18] - c0); end
    end
    n_tests++;
    if (done_c_q.size() !== 1 || done_c_q[0] - c0 !== 56) begin
      n_fail++; $display("FAIL basic_done: count %0d first %0d, want 1 at 56", done_c_q.size(),
                         done_c_q.size() > 0 ? done_c_q[0] - c0 : -1);
    end
    n_tests++; if (rdy_log[c0+56] !== 1'b0) begin n_fail++; $display("FAIL basic_ready56: got %b want 0", rdy_log[c0+56]); end
    n_tests++; if (rdy_log[c0+57] !== 1'b1) begin n_fail++; $display("FAIL basic_ready57: got %b want 1", rdy_log[c0+57]); end
  endtask

  task automatic test_backpressure;
    clear_logs();
    run_cycles(80, M_BP, 10'h040, 10'h0F0, 10'h0, 10'h0);
    n_tests++;
    if (wr_q.size() !== 19) begin n_fail++; $display("FAIL bp_count: got %0d want 19", wr_q.size()); end
    else begin
      n_tests++; if (wr_q[0] !== exp_hdr(10'h040, 10'h0F0)) begin n_fail++; $display("FAIL bp_hdr: got %h want %h", wr_q[0], exp_hdr(10'h040, 10'h0F0)); end
      for (int i = 0; i < 18; i++) begin
        n_tests++;
        if (wr_q[i+1] !== 64'(10'h040 + i)) begin n_fail++; $display("FAIL bp_word%0d: got %h want %h", i, wr_q[i+1], 64'(10'h040 + i)); end
      end
      n_tests++; if (wr_c_q[0] - c0 !== 6) begin n_fail++; $display("FAIL bp_hdr_cycle: got %0d want 6", wr_c_q[0] - c0); end
      n_tests++; if (wr_c_q[8] - c0 !== 33) begin n_fail++; $display("FAIL bp_w7_cycle: got %0d want 33", wr_c_q[8] - c0); end
    end
    n_tests++;
    if (rd_q.size() !== 18) begin n_fail++; $display("FAIL bp_reads: got %0d want 18", rd_q.size()); end
    n_tests++;
    if (done_c_q.size() !== 1 || done_c_q[0] - c0 !== 64) begin
      n_fail++; $display("FAIL bp_done: count %0d first %0d, want 1 at 64", done_c_q.size(),
                         done_c_q.size() > 0 ? done_c_q[0] - c0 : -1);
    end
  endtask

  task automatic test_wrap;
    logic [9:0] a;
    clear_logs();
    run_cycles(70, M_PLAIN, 10'h3FA, 10'h001, 10'h0, 10'h0);
    n_tests++;
    if (rd_q.size() !== 18) begin n_fail++; $display("FAIL wrap_reads: got %0d want 18", rd_q.size()); end
    else begin
      for (int i = 0; i < 18; i++) begin
        a = 10'h3FA + 10'(i);
        n_tests++;
        if (rd_q[i] !== a) begin n_fail++; $display("FAIL wrap_addr%0d: got %h want %h", i, rd_q[i], a); end
      end
    end
    n_tests++;
    if (wr_q.size() !== 19 || wr_q[18] !== 64'h00B) begin
      n_fail++; $display("FAIL wrap_last: count %0d last %h, want 19 ending 00b", wr_q.size(),
                         wr_q.size() > 0 ? wr_q[wr_q.size()-1] : 64'h0);
    end
  endtask

  task automatic test_busy;
    int bad;
    clear_logs();
    run_cycles(90, M_BUSY, 10'h020, 10'h033, 10'h0, 10'h0);
    bad = 0;
    for (int r = 1; r <= 56; r++) if (rdy_log[c0+r] !== 1'b0) bad++;
    n_tests++; if (bad !== 0) begin n_fail++; $display("FAIL busy_ready_low: %0d cycles high, want 0", bad); end
    n_tests++; if (rdy_log[c0+57] !== 1'b1) begin n_fail++; $display("FAIL busy_ready57: got %b want 1", rdy_log[c0+57]); end
    n_tests++; if (wr_q.size() !== 19) begin n_fail++; $display("FAIL busy_count: got %0d want 19", wr_q.size()); end
    n_tests++; if (done_c_q.size() !== 1) begin n_fail++; $display("FAIL busy_done_count: got %0d want 1", done_c_q.size()); end
    n_tests++;
    if (wr_q.size() == 0 || wr_q[0] !== exp_hdr(10'h020, 10'h033)) begin
      n_fail++; $display("FAIL busy_hdr: got %h want %h", wr_q.size() > 0 ? wr_q[0] : 64'h0, exp_hdr(10'h020, 10'h033));
    end
  endtask

  task automatic test_reset_mid;
    clear_logs();
    run_cycles(21, M_RST, 10'h080, 10'h044, 10'h0, 10'h0);
    @(negedge clk);
    n_tests++; if (ready !== 1'b1) begin n_fail++; $display("FAIL rstmid_ready: got %b want 1", ready); end
    n_tests++; if (wr_q.size() !== 7) begin n_fail++; $display("FAIL rstmid_writes: got %0d want 7", wr_q.size()); end
    repeat (3) @(negedge clk);
    n_tests++; if (done_c_q.size() !== 0) begin n_fail++; $display("FAIL rstmid_done: got %0d pulses want 0", done_c_q.size()); end
    tick();
    clear_logs();
    run_cycles(70, M_PLAIN, 10'h100, 10'h0C3, 10'h0, 10'h0);
    n_tests++; if (wr_q.size() !== 19) begin n_fail++; $display("FAIL rstmid_count: got %0d want 19", wr_q.size()); end
    n_tests++;
    if (wr_q.size() < 19 || wr_q[0] !== exp_hdr(10'h100, 10'h0C3) || wr_q[18] !== 64'h111) begin
      n_fail++; $display("FAIL rstmid_packet: hdr %h last %h, want %h / 111",
                         wr_q.size() > 0 ? wr_q[0] : 64'h0, wr_q.size() > 0 ? wr_q[wr_q.size()-1] : 64'h0,
                         exp_hdr(10'h100, 10'h0C3));
    end
    n_tests++; if (done_c_q.size() !== 1) begin n_fail++; $display("FAIL rstmid_done2: got %0d want 1", done_c_q.size()); end
  endtask

  task automatic test_back_to_back;
    clear_logs();
    run_cycles(130, M_B2B, 10'h010, 10'h2A5, 10'h200, 10'h111);
    n_tests++;
    if (wr_q.size() !== 38) begin n_fail++; $display("FAIL b2b_count: got %0d want 38", wr_q.size()); end
    else begin
      n_tests++; if (wr_c_q[19] - c0 !== 58) begin n_fail++; $display("FAIL b2b_hdr_cycle: got %0d want 58", wr_c_q[19] - c0); end
      n_tests++; if (wr_q[19] !== exp_hdr(10'h200, 10'h111)) begin n_fail++; $display("FAIL b2b_hdr: got %h want %h", wr_q[19], exp_hdr(10'h200, 10'h111)); end
      n_tests++; if (wr_q[20] !== 64'h200) begin n_fail++; $display("FAIL b2b_w0: got %h want 200", wr_q[20]); end
      n_tests++; if (wr_q[37] !== 64'h211) begin n_fail++; $display("FAIL b2b_last: got %h want 211", wr_q[37]); end
    end
    n_tests++;
    if (done_c_q.size() !== 2 || done_c_q[1] - c0 !== 113) begin
      n_fail++; $display("FAIL b2b_done: count %0d, want 2 with second at 113", done_c_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_wrap();
    test_busy();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
